uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the UART TX path; sits directly upstream of the 10-bit TX shift register.
- Accepts a byte with a start pulse and builds the 10-bit frame {stop=1, data[7:0], start=0}.
- Pulses the shift register's load enable once, then pulses its shift enable once per baud period, ten times.
- Reports busy/done status to the requester.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- BIT_TICKS, CLK_FREQ/BAUD (434), clock cycles per serial bit. Must be >= 2; benches override it to 4.
- FRAME_BITS, 10, number of shifts per frame. Fixed; not intended for override.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  request to send; sampled only in IDLE.
- tx_data  in  8  byte to send; captured on the accepted tx_start cycle.
- frame  out  10  frame for the shift register parallel input. Bit0 = start (0), bits8:1 = data (LSB at bit1), bit9 = stop (1).
- en_start  out  1  one-cycle load pulse to the shift register.
- en_shift  out  1  one-cycle shift pulse to the shift register.
- tx_busy  out  1  high whenever state != IDLE.
- tx_done  out  1  one-cycle pulse when the frame has finished.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE, tick_cnt=0, bit_cnt=0, frame=10'h3FF.
  - en_start=0, en_shift=0, tx_busy=0, tx_done=0.
  - Reset mid-frame aborts the frame with no further pulses and no tx_done.
- State machine (Moore; outputs decoded from registered state and counters):
  - IDLE: if tx_start=1, capture frame <= {1'b1, tx_data, 1'b0} and go to LOAD. Otherwise stay; frame holds its last value.
  - LOAD (exactly 1 cycle): en_start=1; clear tick_cnt and bit_cnt; go to SEND.
  - SEND:
    - tick_cnt increments each cycle.
    - When tick_cnt == BIT_TICKS-1: en_shift=1, tick_cnt <= 0, bit_cnt <= bit_cnt+1.
    - If that shift is the tenth (bit_cnt == FRAME_BITS-1), go to DONE.
  - DONE (exactly 1 cycle): tx_done=1; go to IDLE.
- Timing, with tx_start accepted at cycle 0:
  - en_start at cycle 1.
  - k-th en_shift at cycle 1 + k*BIT_TICKS, for k = 1..10.
  - tx_done at cycle 2 + 10*BIT_TICKS.
  - IDLE again at cycle 3 + 10*BIT_TICKS, when a new tx_start can be accepted.
- Serial result: the line carries start, d0..d7, stop, each held BIT_TICKS cycles. After the tenth shift the register fill value (1) is on the line, giving an idle-high line.
- Invariants:
  - en_start and en_shift are never high in the same cycle.
  - frame is stable from capture until the next IDLE capture.
- tx_start outside IDLE is ignored: tx_data is not captured and the frame is not extended.
- tx_start held high continuously sends back-to-back frames, one per 3 + 10*BIT_TICKS cycles.
- Counter widths:
  - tick_cnt is $clog2(BIT_TICKS) bits; wrap is only via explicit compare, never natural overflow.
  - bit_cnt is 4 bits and never exceeds 10.

Decomposition:
- Shared package/header uart_pkg:
  - state encoding (IDLE, LOAD, SEND, DONE, 2 bits);
  - constants FRAME_BITS=10, START_BIT=1'b0, STOP_BIT=1'b1;
  - a function computing BIT_TICKS from CLK_FREQ and BAUD.
- One sub-module, baud_tick_counter:
  - inputs clk, rst, clear, enable; output tick;
  - parameter BIT_TICKS;
  - reused later by the RX sampler.

Test Plan (BIT_TICKS=4):
- Reset: assert rst 3 cycles with tx_start=1 -> en_start=0, en_shift=0, tx_busy=0, tx_done=0, frame=10'h3FF throughout.
- Single frame: tx_data=8'hA5, tx_start pulse at cycle 0 ->
  - frame=10'h34A and en_start at cycle 1;
  - en_shift at cycles 5,9,...,41 (10 pulses);
  - tx_done at 42, tx_busy high for cycles 1-42;
  - with the shift register attached, ser_bit sequence 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, then 1.
- Ignored request: during the 8'hA5 frame, tx_start with tx_data=8'h3C at cycle 20 -> frame stays 10'h34A, exactly 10 en_shift pulses, single tx_done at 42.
- Reset mid-frame: rst at cycle 20 -> from cycle 21 tx_busy=0, frame=10'h3FF, no en_shift, no tx_done; a new tx_start then runs a full frame normally.
- Back-to-back: tx_start held high, tx_data=8'h00 then 8'hFF ->
  - en_start at cycles 1 and 44; second frame=10'h3FE;
  - tx_done at 42 and 85.
- Boundary: BIT_TICKS=2 with tx_data=8'h81 -> frame=10'h302, en_shift every 2 cycles (cycles 3..21), tx_done at 22, no overlapping en_start/en_shift.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath: FSM state codes, frame layout
// constants and the baud-divider helper.
package uart_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Whole clock cycles per serial bit; truncation matches the nominal 434 at 50 MHz/115200.
  function automatic int calc_bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_baud_tick_counter.sv
// Free-running divider that emits a one-cycle tick every BIT_TICKS enabled cycles.
// The tick is registered, so it is predicted one count early.
module baud_tick_counter #(
  parameter int BIT_TICKS = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(BIT_TICKS - 2);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Count enabled cycles, wrapping by explicit compare; raise tick while cnt_r sits at LAST_CNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (enable) begin
      if (cnt_r == LAST_CNT) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      tick_r <= (cnt_r == PRE_CNT);
    end else begin
      cnt_r  <= cnt_r;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: captures a byte, loads the 10-bit frame into the
// downstream shift register and paces ten shift pulses at the baud rate.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int BIT_TICKS = calc_bit_ticks(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic [9:0] frame,
  output logic       en_start,
  output logic       en_shift,
  output logic       tx_busy,
  output logic       tx_done
);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [3:0] bit_cnt_r;
  logic [9:0] frame_r;
  logic       en_start_r;
  logic       tx_busy_r;
  logic       tx_done_r;
  logic       tick_s;
  logic       last_bit_s;

  baud_tick_counter #(
    .BIT_TICKS(BIT_TICKS)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_r == ST_LOAD),
    .enable (state_r == ST_SEND),
    .tick   (tick_s)
  );

  assign last_bit_s = (bit_cnt_r == 4'(FRAME_BITS - 1));

  // Next-state decode; SEND leaves only on the tick that carries the tenth shift.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tx_start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: state_nxt_s = ST_SEND;
      ST_SEND: begin
        if (tick_s && last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, bit counter, frame capture, and status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      frame_r    <= 10'h3FF;
      en_start_r <= 1'b0;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      en_start_r <= (state_nxt_s == ST_LOAD);
      tx_busy_r  <= (state_nxt_s != ST_IDLE);
      tx_done_r  <= (state_nxt_s == ST_DONE);

      if ((state_r == ST_IDLE) && tx_start) begin
        frame_r <= {STOP_BIT, tx_data, START_BIT};
      end else begin
        frame_r <= frame_r;
      end

      if (state_r == ST_LOAD) begin
        bit_cnt_r <= 4'd0;
      end else if ((state_r == ST_SEND) && tick_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  assign frame    = frame_r;
  assign en_start = en_start_r;
  assign en_shift = tick_s;
  assign tx_busy  = tx_busy_r;
  assign tx_done  = tx_done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at BIT_TICKS=4 (with a shift-register model)
// and at the BIT_TICKS=2 boundary.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data, tx_data2;
  logic [9:0] frame, frame2;
  logic       en_start, en_shift, tx_busy, tx_done;
  logic       en_start2, en_shift2, tx_busy2, tx_done2;
  logic [9:0] sr;
  int         total = 0;
  int         bad   = 0;
  int         n_shift, n_done;
  logic [9:0] exp_ser;
  logic       e_ser;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.BIT_TICKS(4)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .frame(frame), .en_start(en_start), .en_shift(en_shift),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_ctrl #(.BIT_TICKS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_start(tx_start2), .tx_data(tx_data2),
    .frame(frame2), .en_start(en_start2), .en_shift(en_shift2),
    .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  // Downstream shift register: parallel load, shift right with 1 fill.
  always @(posedge clk) begin
    if (rst) sr <= 10'h3FF;
    else if (en_start) sr <= frame;
    else if (en_shift) sr <= {1'b1, sr[9:1]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic shift4(input int k);
    return (k >= 5) && (k <= 41) && (((k - 1) % 4) == 0);
  endfunction

  initial begin
    rst = 1'b1; tx_start = 1'b1; tx_data = 8'hA5; tx_start2 = 1'b1; tx_data2 = 8'h81;

    // Reset held three cycles with requests pending.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_en_start", i, {9'd0, en_start}, 10'd0);
      chk("rst_en_shift", i, {9'd0, en_shift}, 10'd0);
      chk("rst_busy", i, {9'd0, tx_busy}, 10'd0);
      chk("rst_done", i, {9'd0, tx_done}, 10'd0);
      chk("rst_frame", i, frame, 10'h3FF);
      chk("rst_frame2", i, frame2, 10'h3FF);
    end
    rst = 1'b0; tx_start = 1'b0; tx_start2 = 1'b0;
    step();
    step();
    chk("idle_busy", 0, {9'd0, tx_busy}, 10'd0);

    // Single 8'hA5 frame with an ignored 8'h3C request at cycle 20.
    exp_ser = 10'b11_0100_1010;
    n_shift = 0; n_done = 0;
    tx_data = 8'hA5; tx_start = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      step();
      if (k == 1) tx_start = 1'b0;
      if (k == 20) begin tx_start = 1'b1; tx_data = 8'h3C; end
      if (k == 21) tx_start = 1'b0;
      if (en_shift) n_shift++;
      if (tx_done) n_done++;
      e_ser = ((k >= 2) && (k <= 41)) ? exp_ser[(k - 2) / 4] : 1'b1;
      chk("a5_frame", k, frame, 10'h34A);
      chk("a5_en_start", k, {9'd0, en_start}, {9'd0, (k == 1)});
      chk("a5_en_shift", k, {9'd0, en_shift}, {9'd0, shift4(k)});
      chk("a5_done", k, {9'd0, tx_done}, {9'd0, (k == 42)});
      chk("a5_busy", k, {9'd0, tx_busy}, {9'd0, (k <= 42)});
      chk("a5_ser", k, {9'd0, sr[0]}, {9'd0, e_ser});
    end
    chk("a5_shift_count", 0, 10'(n_shift), 10'd10);
    chk("a5_done_count", 0, 10'(n_done), 10'd1);

    // Reset in the middle of a frame, then a fresh 8'h81 frame.
    tx_data = 8'h5A; tx_start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) tx_start = 1'b0;
      if (k == 20) rst = 1'b1;
      if (k == 21) rst = 1'b0;
      if (k < 20) chk("mid_busy_pre", k, {9'd0, tx_busy}, 10'd1);
      if (k >= 21) begin
        chk("mid_busy", k, {9'd0, tx_busy}, 10'd0);
        chk("mid_frame", k, frame, 10'h3FF);
        chk("mid_en_shift", k, {9'd0, en_shift}, 10'd0);
        chk("mid_done", k, {9'd0, tx_done}, 10'd0);
      end
    end
    tx_data = 8'h81; tx_start = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      step();
      if (k == 1) tx_start = 1'b0;
      chk("post_frame", k, frame, 10'h302);
      chk("post_en_shift", k, {9'd0, en_shift}, {9'd0, shift4(k)});
      chk("post_done", k, {9'd0, tx_done}, {9'd0, (k == 42)});
    end

    // Back-to-back frames with tx_start held high.
    tx_data = 8'h00; tx_start = 1'b1;
    for (int k = 1; k <= 86; k++) begin
      step();
      if (k == 1) tx_data = 8'hFF;
      if (k == 85) tx_start = 1'b0;
      chk("b2b_en_start", k, {9'd0, en_start}, {9'd0, (k == 1) || (k == 44)});
      chk("b2b_done", k, {9'd0, tx_done}, {9'd0, (k == 42) || (k == 85)});
      chk("b2b_frame", k, frame, (k >= 44) ? 10'h3FE : 10'h200);
      chk("b2b_busy", k, {9'd0, tx_busy}, {9'd0, (k != 43) && (k != 86)});
    end

    // BIT_TICKS=2 boundary.
    tx_data2 = 8'h81; tx_start2 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1) tx_start2 = 1'b0;
      chk("bt2_frame", k, frame2, 10'h302);
      chk("bt2_en_start", k, {9'd0, en_start2}, {9'd0, (k == 1)});
      chk("bt2_en_shift", k, {9'd0, en_shift2}, {9'd0, (k >= 3) && (k <= 21) && ((k % 2) == 1)});
      chk("bt2_done", k, {9'd0, tx_done2}, {9'd0, (k == 22)});
      chk("bt2_overlap", k, {9'd0, en_start2 & en_shift2}, 10'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
